// File: rtl/ber_checker.sv
// Bit-error-ratio checker: compares rx_data against exp_data per valid beat and
// accumulates compared/errored bit counts over a window. BER_FIRST_ERR_EN adds first-error capture.
module ber_checker #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 32,
  parameter int WIN_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [WIN_W-1:0]  win_len,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] exp_data,
  input  logic [DATA_W-1:0] rx_data,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] err_vec,
  output logic [CNT_W-1:0]  bit_cnt,
  output logic [CNT_W-1:0]  err_cnt,
  output logic              sat,
`ifdef BER_FIRST_ERR_EN
  output logic [WIN_W-1:0]  first_err_idx,
  output logic              first_err_vld,
`endif
  output logic [1:0]        dbg_state
);

  localparam int POP_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W:0] DATA_INC = (CNT_W + 1)'(DATA_W);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_MEASURE = 2'd1,
    S_DRAIN   = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [WIN_W-1:0]   rem_q, rem_d;
  logic               free_q, free_d;
  logic               drain_q, drain_d;
  logic               s1_vld_q, s1_vld_d;
  logic [DATA_W-1:0]  err_vec_q, err_vec_d;
  logic [POP_W-1:0]   pop_q, pop_d;
  logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;
  logic               sat_q, sat_d;

  logic               accept;
  logic               start_ok;
  logic [DATA_W-1:0]  diff;
  logic [POP_W-1:0]   pop;
  logic [CNT_W:0]     bit_sum;
  logic [CNT_W:0]     err_sum;

  // Handshake: a word is taken on any cycle in MEASURE with in_valid high; there is no backpressure.
  assign accept   = (state_q == S_MEASURE) && in_valid;
  assign start_ok = start && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign diff     = exp_data ^ rx_data;

  always_comb begin
    pop = '0;
    for (int i = 0; i < DATA_W; i++) begin
      pop = pop + POP_W'(diff[i]);
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      rem_q   <= '0;
      free_q  <= 1'b0;
      drain_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      free_q  <= free_d;
      drain_q <= drain_d;
    end
  end

  // Next-state logic; abort and window end both lead to the same DRAIN entry.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    free_d  = free_q;
    drain_d = drain_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_MEASURE;
          rem_d   = win_len;
          free_d  = (win_len == '0);
          drain_d = 1'b0;
        end
      end
      S_MEASURE: begin
        if (accept && !free_q) begin
          rem_d = rem_q - WIN_W'(1);
          if (rem_q == WIN_W'(1)) begin
            state_d = S_DRAIN;
            drain_d = 1'b0;
          end
        end
        if (abort) begin
          state_d = S_DRAIN;
          drain_d = 1'b0;
        end
      end
      S_DRAIN: begin
        if (drain_q) begin
          state_d = S_DONE;
          drain_d = 1'b0;
        end else begin
          drain_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy      = (state_q == S_MEASURE) || (state_q == S_DRAIN);
    done      = (state_q == S_DONE);
    dbg_state = state_q;
  end

  // Two-stage datapath: stage 1 registers XOR and popcount, stage 2 accumulates.
  always_comb begin
    err_vec_d = err_vec_q;
    pop_d     = pop_q;
    s1_vld_d  = accept;
    bit_cnt_d = bit_cnt_q;
    err_cnt_d = err_cnt_q;
    sat_d     = sat_q;
    bit_sum   = {1'b0, bit_cnt_q} + DATA_INC;
    err_sum   = {1'b0, err_cnt_q} + (CNT_W + 1)'(pop_q);
    if (start_ok) begin
      err_vec_d = '0;
      pop_d     = '0;
      s1_vld_d  = 1'b0;
      bit_cnt_d = '0;
      err_cnt_d = '0;
      sat_d     = 1'b0;
    end else begin
      if (accept) begin
        err_vec_d = diff;
        pop_d     = pop;
      end
      if (s1_vld_q) begin
        if (bit_sum[CNT_W]) begin
          bit_cnt_d = '1;
          sat_d     = 1'b1;
        end else begin
          bit_cnt_d = bit_sum[CNT_W-1:0];
        end
        if (err_sum[CNT_W]) begin
          err_cnt_d = '1;
          sat_d     = 1'b1;
        end else begin
          err_cnt_d = err_sum[CNT_W-1:0];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld_q  <= 1'b0;
      err_vec_q <= '0;
      pop_q     <= '0;
      bit_cnt_q <= '0;
      err_cnt_q <= '0;
      sat_q     <= 1'b0;
    end else begin
      s1_vld_q  <= s1_vld_d;
      err_vec_q <= err_vec_d;
      pop_q     <= pop_d;
      bit_cnt_q <= bit_cnt_d;
      err_cnt_q <= err_cnt_d;
      sat_q     <= sat_d;
    end
  end

  assign err_vec = err_vec_q;
  assign bit_cnt = bit_cnt_q;
  assign err_cnt = err_cnt_q;
  assign sat     = sat_q;

`ifdef BER_FIRST_ERR_EN
  logic [WIN_W-1:0] widx_q, widx_d;
  logic [WIN_W-1:0] first_idx_q, first_idx_d;
  logic             first_vld_q, first_vld_d;

  // Capture happens on the acceptance edge, so the flag is visible in stage 1.
  always_comb begin
    widx_d      = widx_q;
    first_idx_d = first_idx_q;
    first_vld_d = first_vld_q;
    if (start_ok) begin
      widx_d      = '0;
      first_idx_d = '0;
      first_vld_d = 1'b0;
    end else if (accept) begin
      widx_d = widx_q + WIN_W'(1);
      if ((diff != '0) && !first_vld_q) begin
        first_idx_d = widx_q;
        first_vld_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      widx_q      <= '0;
      first_idx_q <= '0;
      first_vld_q <= 1'b0;
    end else begin
      widx_q      <= widx_d;
      first_idx_q <= first_idx_d;
      first_vld_q <= first_vld_d;
    end
  end

  assign first_err_idx = first_idx_q;
  assign first_err_vld = first_vld_q;
`endif

endmodule
